sysbus_mem_responder: RTL and testbench

- Synthesizable Sysbus memory-side responder. It is the far end of the core's bus master port (bus_reqcyc/bus_req/bus_reqtag out of the core, bus_resp* back into it).
- Accepts line read and line write requests and returns or absorbs 8-beat bursts of 64-bit data from an internal word-addressed RAM.
- Used as the memory model in core-level simulation and as the on-chip RAM backend in FPGA builds.

---
 rtl/sysbus_mem_responder_if.sv | 24 ++
 rtl/sysbus_mem_responder.sv | 131 +++++++++++++
 tb/tb_sysbus_mem_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sysbus_mem_responder_if.sv
// rtl/sysbus_mem_responder_if.sv - Sysbus request/response signal bundle between core master and memory responder
interface sysbus_mem_responder_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic                      bus_respack;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/sysbus_mem_responder.sv
// rtl/sysbus_mem_responder.sv - Sysbus line-burst memory responder; SYSBUS_CRITICAL_WORD_FIRST_EN enables wrap-order reads
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int LINE_BEATS     = 8,
    parameter int READ_LATENCY   = 4
) (
    input logic                   clk,
    input logic                   reset,
    sysbus_mem_responder_if.slave bus
);
    localparam int AW     = $clog2(MEM_WORDS);
    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int LINE_W = AW - BEAT_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        RD_WAIT,
        RD_BURST,
        WR_DATA
    } state_t;

    state_t                    state;
    logic [LINE_W-1:0]         line;
    logic [BUS_TAG_WIDTH-1:0]  tag;
    logic [BEAT_W-1:0]         beat;
    logic [BEAT_W-1:0]         cnt;
    logic [3:0]                lat_cnt;
    logic                      reqack_q;
    logic                      respcyc_q;
    logic [BUS_DATA_WIDTH-1:0] resp_q;
    logic [BUS_TAG_WIDTH-1:0]  resptag_q;

    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [BEAT_W-1:0]         beat_next;
    logic                      mem_we;

    assign beat_next = beat + 1'b1;

    // reqack_q high marks the cycle right after a consumed beat, which must be ignored
    assign mem_we = !reset && (state == WR_DATA) && bus.bus_reqcyc && !reqack_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[{line, beat}] <= bus.bus_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            line      <= '0;
            tag       <= '0;
            beat      <= '0;
            cnt       <= '0;
            lat_cnt   <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            reqack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.bus_reqcyc && !reqack_q) begin
                        line     <= bus.bus_req[3+AW-1:3+BEAT_W];
                        tag      <= bus.bus_reqtag;
                        cnt      <= '0;
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
                        beat     <= bus.bus_reqtag[BUS_TAG_WIDTH-1] ? '0 : bus.bus_req[3+BEAT_W-1:3];
`else
                        beat     <= '0;
`endif
                        reqack_q <= 1'b1;
                        state    <= ACK;
                    end
                end
                ACK: begin
                    if (tag[BUS_TAG_WIDTH-1]) begin
                        state <= WR_DATA;
                    end else begin
                        lat_cnt <= 4'(READ_LATENCY);
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt <= 4'd1) begin
                        respcyc_q <= 1'b1;
                        resp_q    <= mem[{line, beat}];
                        resptag_q <= tag;
                        state     <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (bus.bus_respack) begin
                        cnt  <= cnt + 1'b1;
                        beat <= beat_next;
                        if (cnt == LAST_BEAT) begin
                            respcyc_q <= 1'b0;
                            resp_q    <= '0;
                            resptag_q <= '0;
                            state     <= IDLE;
                        end else begin
                            resp_q <= mem[{line, beat_next}];
                        end
                    end
                end
                WR_DATA: begin
                    if (bus.bus_reqcyc && !reqack_q) begin
                        reqack_q <= 1'b1;
                        beat     <= beat_next;
                        cnt      <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bus_reqack  = reqack_q;
    assign bus.bus_respcyc = respcyc_q;
    assign bus.bus_resp    = resp_q;
    assign bus.bus_resptag = resptag_q;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb/tb_sysbus_mem_responder.sv - directed bench for sysbus_mem_responder
module tb_sysbus_mem_responder;
    localparam int RD_LAT = 4;
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
    localparam int CWF = 1;
`else
    localparam int CWF = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    sysbus_mem_responder_if bus_if ();

    sysbus_mem_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic wait_reqack(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.bus_reqack === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s: reqack observed=0 required=1 within 20 cycles", name);
        end
    endtask

    task automatic issue_req(input logic [63:0] addr, input logic [12:0] tag);
        bus_if.bus_req    = addr;
        bus_if.bus_reqtag = tag;
        bus_if.bus_reqcyc = 1'b1;
        wait_reqack("req_ack");
    endtask

    task automatic write_beats(input logic [63:0] base, input logic [63:0] step);
        for (int i = 0; i < 8; i++) begin
            bus_if.bus_req    = base + step * 64'(i);
            bus_if.bus_reqcyc = 1'b1;
            wait_reqack("wr_beat_ack");
        end
        bus_if.bus_reqcyc = 1'b0;
        bus_if.bus_req    = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus_if.bus_reqack !== 1'b0) begin
                miscompares++;
                $display("FAIL wr_extra_ack: reqack observed=%b required=0", bus_if.bus_reqack);
            end
        end
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [63:0] base, input logic [63:0] step);
        issue_req(addr, 13'h1000);
        write_beats(base, step);
    endtask

    task automatic recv_burst(input logic [12:0] tag, input int start, input logic [63:0] base,
                              input logic [63:0] step, input int stall_beat, input int stall_len,
                              input int abort_beat);
        int n = 0;
        logic [63:0] exp;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus_if.bus_respcyc === 1'b1) break;
            vectors++;
            if (bus_if.bus_reqack !== 1'b0) begin
                miscompares++;
                $display("FAIL rd_wait_ack: reqack observed=%b required=0", bus_if.bus_reqack);
            end
        end
        vectors++;
        if (n != RD_LAT + 1) begin
            miscompares++;
            $display("FAIL rd_latency: first respcyc after %0d cycles, required %0d", n, RD_LAT + 1);
        end
        for (int k = 0; k < 8; k++) begin
            exp = base + step * 64'((start + k) % 8);
            vectors++;
            if (bus_if.bus_respcyc !== 1'b1 || bus_if.bus_resp !== exp) begin
                miscompares++;
                $display("FAIL rd_beat%0d: respcyc=%b resp=%h required respcyc=1 resp=%h",
                         k, bus_if.bus_respcyc, bus_if.bus_resp, exp);
            end
            vectors++;
            if (bus_if.bus_resptag !== tag) begin
                miscompares++;
                $display("FAIL rd_tag%0d: resptag=%h required=%h", k, bus_if.bus_resptag, tag);
            end
            vectors++;
            if (bus_if.bus_reqack !== 1'b0) begin
                miscompares++;
                $display("FAIL rd_burst_ack%0d: reqack observed=%b required=0", k, bus_if.bus_reqack);
            end
            if (k == abort_beat) begin
                reset = 1'b1;
                bus_if.bus_respack = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                vectors++;
                if (bus_if.bus_respcyc !== 1'b0 || bus_if.bus_resp !== 64'h0 || bus_if.bus_resptag !== 13'h0) begin
                    miscompares++;
                    $display("FAIL rd_abort: respcyc=%b resp=%h resptag=%h required all 0",
                             bus_if.bus_respcyc, bus_if.bus_resp, bus_if.bus_resptag);
                end
                return;
            end
            if (k == stall_beat) begin
                bus_if.bus_respack = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    vectors++;
                    if (bus_if.bus_respcyc !== 1'b1 || bus_if.bus_resp !== exp) begin
                        miscompares++;
                        $display("FAIL rd_stall%0d: respcyc=%b resp=%h required respcyc=1 resp=%h",
                                 s, bus_if.bus_respcyc, bus_if.bus_resp, exp);
                    end
                end
            end
            bus_if.bus_respack = 1'b1;
            @(negedge clk);
        end
        bus_if.bus_respack = 1'b0;
        vectors++;
        if (bus_if.bus_respcyc !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_end: respcyc observed=%b required=0", bus_if.bus_respcyc);
        end
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag, input int start,
                           input logic [63:0] base, input logic [63:0] step,
                           input int stall_beat, input int stall_len, input int abort_beat);
        issue_req(addr, tag);
        bus_if.bus_reqcyc = 1'b0;
        recv_burst(tag, start, base, step, stall_beat, stall_len, abort_beat);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus_if.bus_reqack, bus_if.bus_respcyc} !== 2'b00 || bus_if.bus_resp !== 64'h0 ||
                bus_if.bus_resptag !== 13'h0) begin
                miscompares++;
                $display("FAIL reset_idle%0d: reqack=%b respcyc=%b resp=%h resptag=%h required all 0",
                         i, bus_if.bus_reqack, bus_if.bus_respcyc, bus_if.bus_resp, bus_if.bus_resptag);
            end
        end
    endtask

    task automatic test_reset_release_accept;
        reset = 1'b1;
        bus_if.bus_req    = 64'h0;
        bus_if.bus_reqtag = 13'h1000;
        bus_if.bus_reqcyc = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus_if.bus_reqack !== 1'b1) begin
            miscompares++;
            $display("FAIL release_accept: reqack observed=%b required=1", bus_if.bus_reqack);
        end
        write_beats(64'hA0, 64'h1);
    endtask

    task automatic test_write_read;
        do_write(64'h1000, 64'h11, 64'h11);
        do_read(64'h1000, 13'h0155, 0, 64'h11, 64'h11, -1, 0, -1);
    endtask

    task automatic test_read_stall;
        do_read(64'h1000, 13'h0155, 0, 64'h11, 64'h11, 2, 3, -1);
    endtask

    task automatic test_back_to_back;
        issue_req(64'h1000, 13'h0101);
        bus_if.bus_req    = 64'h40000;
        bus_if.bus_reqtag = 13'h00AA;
        recv_burst(13'h0101, 0, 64'h11, 64'h11, -1, 0, -1);
        wait_reqack("held_req_ack");
        bus_if.bus_reqcyc = 1'b0;
        recv_burst(13'h00AA, 0, 64'hA0, 64'h1, -1, 0, -1);
    endtask

    task automatic test_addr_wrap;
        do_read(64'h40000, 13'h0042, 0, 64'hA0, 64'h1, -1, 0, -1);
    endtask

    task automatic test_critical_word_first;
        do_read(64'h1028, 13'h0033, (CWF != 0) ? 5 : 0, 64'h11, 64'h11, -1, 0, 3);
        repeat (2) @(negedge clk);
        do_read(64'h1000, 13'h0155, 0, 64'h11, 64'h11, -1, 0, -1);
    endtask

    initial begin
        bus_if.bus_reqcyc  = 1'b0;
        bus_if.bus_req     = '0;
        bus_if.bus_reqtag  = '0;
        bus_if.bus_respack = 1'b0;
        test_reset;
        test_reset_release_accept;
        test_write_read;
        test_read_stall;
        test_back_to_back;
        test_addr_wrap;
        test_critical_word_first;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
